id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage directly downstream of instruction fetch. It latches fetch's PC and instruction into an IF/ID register and reads a 32x32 register file with a write-back port.
- Resolves beq/bne/j/jal/jr in decode and drives branch_taken, jump_taken, branch_offset, new_addr and stall back to fetch.
- Detects load-use and branch-operand hazards and inserts bubbles.
- Presents a registered ID/EX bundle to execute.

Parameters:
- WORD, 32, datapath width; uses the codebase's WORD constant.
- REGS, 32, register file depth; register 0 is hardwired to zero.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- if_pc  in  WORD  PC from fetch (byte address).
- if_instruction  in  WORD  instruction from fetch.
- wb_reg_write  in  1  write-back enable.
- wb_rd  in  5  write-back register index.
- wb_data  in  WORD  write-back data.
- ex_reg_write  in  1  instruction in execute writes a register.
- ex_mem_read  in  1  instruction in execute is a load.
- ex_rd  in  5  execute destination register.
- mem_reg_write  in  1  instruction in memory stage writes a register.
- mem_mem_read  in  1  instruction in memory stage is a load.
- mem_rd  in  5  memory-stage destination register.
- mem_result  in  WORD  memory-stage ALU result.
- stall  out  1  hold PC (to fetch).
- branch_taken  out  1  to fetch.
- branch_offset  out  WORD  sign-extended imm16, in words.
- jump_taken  out  1  to fetch.
- new_addr  out  WORD  jump target, in words.
- idex_valid  out  1  ID/EX bundle valid.
- idex_pc  out  WORD  PC of the instruction in ID/EX.
- idex_opcode  out  6
- idex_funct  out  6
- idex_rs  out  5
- idex_rt  out  5
- idex_rd  out  5  destination: rd for R-type, rt for I-type, 31 for jal, 0 if no write.
- idex_rs_val  out  WORD
- idex_rt_val  out  WORD
- idex_imm  out  WORD  sign-extended imm16.
- idex_link  out  WORD  if_pc-of-instruction + 4, used by jal.

Behaviour:
- Reset (rst=0, asynchronous): IF/ID valid=0 and contents 0; all idex_* outputs 0; all registers 0. Combinational outputs derived from an invalid IF/ID are 0.
- IF/ID register, at posedge:
  - stall=1: hold.
  - else if branch_taken or jump_taken: load valid=0 (flush the wrong-path fetch; no delay slot).
  - else: load if_pc, if_instruction, valid=1.
- Register file read (combinational):
  - rs/rt = instr[25:21]/[20:16]; index 0 reads 0.
  - Write-first bypass: wb_reg_write && wb_rd==index && index!=0 returns wb_data.
  - Write at posedge when wb_reg_write && wb_rd!=0.
- Branch operand forwarding: mem_reg_write && !mem_mem_read && mem_rd==operand && operand!=0 selects mem_result; otherwise the regfile value.
- Stall (combinational, only when IF/ID valid):
  - (a) Load-use: ex_mem_read && ex_rd!=0 && (ex_rd==rs || (uses_rt && ex_rd==rt)). uses_rt holds for R-type, beq, bne, sw (6'h2B).
  - (b) beq/bne/jr operand matches ex_rd with ex_reg_write && ex_rd!=0.
  - (c) beq/bne/jr operand matches mem_rd with mem_mem_read && mem_rd!=0.
- Control, suppressed to 0 while stall=1:
  - beq (6'h04): branch_taken = (rs_val==rt_val).
  - bne (6'h05): branch_taken = (rs_val!=rt_val).
  - branch_offset = sign-extended imm always. Fetch's PC equals branch PC+4 at resolution, so target = branch PC+4+imm*4.
  - j (6'h02) / jal (6'h03): jump_taken=1, new_addr = {2'b00, pc[31:28], instr[25:0]}.
  - jr (opcode 0, funct 6'h08): jump_taken=1, new_addr = {2'b00, rs_val[31:2]}.
  - branch_taken and jump_taken are never both 1.
- ID/EX register, at posedge:
  - stall=1 or IF/ID invalid: bubble (idex_valid=0, all fields 0).
  - else: load decoded fields.
  - Latency: one cycle from IF/ID to ID/EX.
  - beq, bne, j, jr and sw produce idex_rd=0.
- Simultaneous: stall overrides taken branch/jump; the branch re-evaluates next cycle with the same IF/ID.

Test Plan:
- Reset mid-stream: drop rst with valid IF/ID and ID/EX -> stall=0, idex_valid=0, all regs read 0, immediately without a clock edge.
- Write-back bypass: wb writes r5=0x1234 while IF/ID holds add r3,r5,r0 -> next edge idex_rs_val=0x1234; wb to r0 -> r0 still reads 0.
- Load-use: ex_mem_read=1, ex_rd=8 and IF/ID holds add r1,r8,r2 -> stall=1 for exactly 1 cycle, one bubble (idex_valid=0), then the add issues with unchanged fields.
- beq taken with forwarding: mem_rd=4, mem_result=7, mem_reg_write=1, r5=7, beq r4,r5,-3 -> branch_taken=1, branch_offset=0xFFFFFFFD; next IF/ID valid=0.
- Branch hazard: ex_reg_write=1, ex_rd=4 with bne r4,r0 -> stall=1, branch_taken=0; after the hazard clears, bne resolves normally.
- jal at PC 0x00400010, target 0x0100000 -> jump_taken=1, new_addr=0x00100000; next edge idex_rd=31, idex_link=0x00400014; jr r31 with r31=0x00400014 -> new_addr=0x00100005.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, 32-entry register file, in-decode branch/jump resolution,
// hazard stalls and a registered ID/EX bundle for execute.
module id_stage #(
    parameter int unsigned WORD = 32,
    parameter int unsigned REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] if_pc,
    input  logic [WORD-1:0] if_instruction,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [WORD-1:0] wb_data,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            mem_reg_write,
    input  logic            mem_mem_read,
    input  logic [4:0]      mem_rd,
    input  logic [WORD-1:0] mem_result,
    output logic            stall,
    output logic            branch_taken,
    output logic [WORD-1:0] branch_offset,
    output logic            jump_taken,
    output logic [WORD-1:0] new_addr,
    output logic            idex_valid,
    output logic [WORD-1:0] idex_pc,
    output logic [5:0]      idex_opcode,
    output logic [5:0]      idex_funct,
    output logic [4:0]      idex_rs,
    output logic [4:0]      idex_rt,
    output logic [4:0]      idex_rd,
    output logic [WORD-1:0] idex_rs_val,
    output logic [WORD-1:0] idex_rt_val,
    output logic [WORD-1:0] idex_imm,
    output logic [WORD-1:0] idex_link
);

    typedef struct packed {
        logic            valid;
        logic [WORD-1:0] pc;
        logic [5:0]      opcode;
        logic [5:0]      funct;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [WORD-1:0] rs_val;
        logic [WORD-1:0] rt_val;
        logic [WORD-1:0] imm;
        logic [WORD-1:0] link;
    } idex_t;

    logic            r_ifid_valid;
    logic [WORD-1:0] r_ifid_pc;
    logic [WORD-1:0] r_ifid_instr;
    logic [WORD-1:0] r_regs [REGS];
    idex_t           r_idex;
    idex_t           w_idex_d;

    logic [5:0]      w_opcode;
    logic [5:0]      w_funct;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_dest;
    logic [WORD-1:0] w_imm;
    logic [WORD-1:0] w_rs_rf;
    logic [WORD-1:0] w_rt_rf;
    logic [WORD-1:0] w_rs_val;
    logic [WORD-1:0] w_rt_val;
    logic            w_is_beq, w_is_bne, w_is_br, w_is_j, w_is_jal, w_is_jr, w_uses_rt;
    logic            w_load_use, w_ex_hz, w_mem_hz, w_stall, w_go;

    assign w_opcode = r_ifid_instr[31:26];
    assign w_rs     = r_ifid_instr[25:21];
    assign w_rt     = r_ifid_instr[20:16];
    assign w_funct  = r_ifid_instr[5:0];
    assign w_imm    = {{(WORD-16){r_ifid_instr[15]}}, r_ifid_instr[15:0]};

    assign w_is_beq  = (w_opcode == 6'h04);
    assign w_is_bne  = (w_opcode == 6'h05);
    assign w_is_br   = w_is_beq || w_is_bne;
    assign w_is_j    = (w_opcode == 6'h02);
    assign w_is_jal  = (w_opcode == 6'h03);
    assign w_is_jr   = (w_opcode == 6'h00) && (w_funct == 6'h08);
    assign w_uses_rt = (w_opcode == 6'h00) || w_is_br || (w_opcode == 6'h2B);

    // Write-first: a same-cycle write-back is visible to the read.
    assign w_rs_rf = (w_rs == 5'd0) ? '0 :
                     (wb_reg_write && wb_rd == w_rs) ? wb_data : r_regs[w_rs];
    assign w_rt_rf = (w_rt == 5'd0) ? '0 :
                     (wb_reg_write && wb_rd == w_rt) ? wb_data : r_regs[w_rt];

    assign w_rs_val = (mem_reg_write && !mem_mem_read && mem_rd == w_rs && w_rs != 5'd0)
                      ? mem_result : w_rs_rf;
    assign w_rt_val = (mem_reg_write && !mem_mem_read && mem_rd == w_rt && w_rt != 5'd0)
                      ? mem_result : w_rt_rf;

    assign w_load_use = ex_mem_read && ex_rd != 5'd0 &&
                        (ex_rd == w_rs || (w_uses_rt && ex_rd == w_rt));
    assign w_ex_hz    = ex_reg_write && ex_rd != 5'd0 &&
                        ((w_is_br && (ex_rd == w_rs || ex_rd == w_rt)) ||
                         (w_is_jr && ex_rd == w_rs));
    assign w_mem_hz   = mem_mem_read && mem_rd != 5'd0 &&
                        ((w_is_br && (mem_rd == w_rs || mem_rd == w_rt)) ||
                         (w_is_jr && mem_rd == w_rs));
    assign w_stall    = r_ifid_valid && (w_load_use || w_ex_hz || w_mem_hz);
    assign w_go       = r_ifid_valid && !w_stall;

    assign stall         = w_stall;
    assign branch_taken  = w_go && ((w_is_beq && w_rs_val == w_rt_val) ||
                                    (w_is_bne && w_rs_val != w_rt_val));
    assign jump_taken    = w_go && (w_is_j || w_is_jal || w_is_jr);
    assign branch_offset = r_ifid_valid ? w_imm : '0;
    assign new_addr      = !jump_taken ? '0 :
                           w_is_jr ? {2'b00, w_rs_val[31:2]} :
                                     {2'b00, r_ifid_pc[31:28], r_ifid_instr[25:0]};

    always_comb begin
        w_dest = w_rt;
        case (w_opcode)
            6'h00:                      w_dest = w_is_jr ? 5'd0 : r_ifid_instr[15:11];
            6'h02, 6'h04, 6'h05, 6'h2B: w_dest = 5'd0;
            6'h03:                      w_dest = 5'd31;
            default:                    w_dest = w_rt;
        endcase
    end

    always_comb begin
        w_idex_d = '0;
        if (w_go) begin
            w_idex_d.valid  = 1'b1;
            w_idex_d.pc     = r_ifid_pc;
            w_idex_d.opcode = w_opcode;
            w_idex_d.funct  = w_funct;
            w_idex_d.rs     = w_rs;
            w_idex_d.rt     = w_rt;
            w_idex_d.rd     = w_dest;
            w_idex_d.rs_val = w_rs_rf;
            w_idex_d.rt_val = w_rt_rf;
            w_idex_d.imm    = w_imm;
            w_idex_d.link   = r_ifid_pc + WORD'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
        end else if (!w_stall) begin
            if (branch_taken || jump_taken) begin
                r_ifid_valid <= 1'b0;
                r_ifid_pc    <= '0;
                r_ifid_instr <= '0;
            end else begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= if_pc;
                r_ifid_instr <= if_instruction;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REGS; i++) r_regs[i] <= '0;
        end else if (wb_reg_write && wb_rd != 5'd0) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_idex <= '0;
        else      r_idex <= w_idex_d;
    end

    assign idex_valid  = r_idex.valid;
    assign idex_pc     = r_idex.pc;
    assign idex_opcode = r_idex.opcode;
    assign idex_funct  = r_idex.funct;
    assign idex_rs     = r_idex.rs;
    assign idex_rt     = r_idex.rt;
    assign idex_rd     = r_idex.rd;
    assign idex_rs_val = r_idex.rs_val;
    assign idex_rt_val = r_idex.rt_val;
    assign idex_imm    = r_idex.imm;
    assign idex_link   = r_idex.link;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios with a scoreboard of expected
// ID/EX bundles built from a shadow register file.
module tb_id_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] link;
    } idex_t;

    localparam logic [31:0] NOP = 32'h0;

    logic        clk, rst;
    logic [31:0] if_pc, if_instruction, wb_data, mem_result;
    logic        wb_reg_write, ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
    logic [4:0]  wb_rd, ex_rd, mem_rd;
    logic        stall, branch_taken, jump_taken, idex_valid;
    logic [31:0] branch_offset, new_addr, idex_pc, idex_rs_val, idex_rt_val, idex_imm, idex_link;
    logic [5:0]  idex_opcode, idex_funct;
    logic [4:0]  idex_rs, idex_rt, idex_rd;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] model_rf [32];
    idex_t       sb_q [$];
    idex_t       got, exp_b;

    id_stage dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .mem_result(mem_result), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump_taken(jump_taken), .new_addr(new_addr),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_opcode(idex_opcode),
        .idex_funct(idex_funct), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .idex_rs_val(idex_rs_val), .idex_rt_val(idex_rt_val), .idex_imm(idex_imm),
        .idex_link(idex_link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // Reference decode of one instruction against the shadow register file.
    function automatic idex_t exp_idex(input logic [31:0] pc, input logic [31:0] ins);
        idex_t e;
        e.valid  = 1'b1;
        e.pc     = pc;
        e.opcode = ins[31:26];
        e.funct  = ins[5:0];
        e.rs     = ins[25:21];
        e.rt     = ins[20:16];
        e.rs_val = (e.rs == 0) ? 32'd0 : model_rf[e.rs];
        e.rt_val = (e.rt == 0) ? 32'd0 : model_rf[e.rt];
        e.imm    = {{16{ins[15]}}, ins[15:0]};
        e.link   = pc + 32'd4;
        case (e.opcode)
            6'h00:                      e.rd = (e.funct == 6'h08) ? 5'd0 : ins[15:11];
            6'h02, 6'h04, 6'h05, 6'h2B: e.rd = 5'd0;
            6'h03:                      e.rd = 5'd31;
            default:                    e.rd = e.rt;
        endcase
        return e;
    endfunction

    function automatic idex_t dut_idex();
        idex_t g;
        g = {idex_valid, idex_pc, idex_opcode, idex_funct, idex_rs, idex_rt, idex_rd,
             idex_rs_val, idex_rt_val, idex_imm, idex_link};
        return g;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
        if_pc = pc;
        if_instruction = ins;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_reg_write = 1'b1;
        wb_rd = rd;
        wb_data = data;
        if (rd != 0) model_rf[rd] = data;
        cyc();
        wb_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        logic [97:0] v;
        #1;
        v = {stall, branch_taken, jump_taken, branch_offset, new_addr, idex_pc};
        n_vec++;
        if (v !== '0) begin
            n_miss++;
            $display("FAIL reset_comb got=%h exp=0", v);
        end
        n_vec++;
        if (idex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_idex_valid got=%b exp=0", idex_valid);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_bypass();
        fetch(32'h100, enc_r(5'd5, 5'd0, 5'd3, 6'h20));
        cyc();
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        model_rf[5] = 32'h1234;
        fetch(32'h104, NOP);
        sb_q.push_back(exp_idex(32'h100, enc_r(5'd5, 5'd0, 5'd3, 6'h20)));
        cyc();
        got = dut_idex(); exp_b = sb_q.pop_front();
        n_vec++;
        if (got !== exp_b) begin
            n_miss++;
            $display("FAIL wb_bypass idex got=%h exp=%h", got, exp_b);
        end
        // Write to r0 must neither bypass nor stick.
        wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
        fetch(32'h108, enc_r(5'd0, 5'd0, 5'd3, 6'h20));
        cyc();
        fetch(32'h10C, NOP);
        sb_q.push_back(exp_idex(32'h108, enc_r(5'd0, 5'd0, 5'd3, 6'h20)));
        cyc();
        wb_reg_write = 1'b0;
        got = dut_idex(); exp_b = sb_q.pop_front();
        n_vec++;
        if (got !== exp_b) begin
            n_miss++;
            $display("FAIL wb_r0 idex got=%h exp=%h", got, exp_b);
        end
    endtask

    task automatic test_load_use();
        wb_write(5'd8, 32'h11);
        wb_write(5'd2, 32'h22);
        fetch(32'h200, enc_r(5'd8, 5'd2, 5'd1, 6'h20));
        cyc();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8;
        fetch(32'h204, NOP);
        sb_q.push_back(exp_idex(32'h200, enc_r(5'd8, 5'd2, 5'd1, 6'h20)));
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_miss++;
            $display("FAIL load_use_stall got=%b exp=1", stall);
        end
        cyc();
        n_vec++;
        if (idex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL load_use_bubble got=%b exp=0", idex_valid);
        end
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_miss++;
            $display("FAIL load_use_release got=%b exp=0", stall);
        end
        cyc();
        got = dut_idex(); exp_b = sb_q.pop_front();
        n_vec++;
        if (got !== exp_b) begin
            n_miss++;
            $display("FAIL load_use_issue idex got=%h exp=%h", got, exp_b);
        end
        cyc();
        n_vec++;
        if ({idex_valid, idex_pc} !== {1'b1, 32'h204}) begin
            n_miss++;
            $display("FAIL load_use_next got=%b/%h exp=1/00000204", idex_valid, idex_pc);
        end
    endtask

    task automatic test_beq_forward();
        wb_write(5'd5, 32'd7);
        fetch(32'h300, enc_i(6'h04, 5'd4, 5'd5, 16'hFFFD));
        cyc();
        mem_reg_write = 1'b1; mem_mem_read = 1'b0; mem_rd = 5'd4; mem_result = 32'd7;
        fetch(32'h304, enc_r(5'd9, 5'd9, 5'd9, 6'h20));
        #1;
        n_vec++;
        if ({stall, branch_taken, jump_taken, branch_offset} !== {3'b010, 32'hFFFF_FFFD}) begin
            n_miss++;
            $display("FAIL beq_fwd got=%b%b%b/%h exp=010/fffffffd",
                     stall, branch_taken, jump_taken, branch_offset);
        end
        cyc();
        mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
        fetch(32'h308, NOP);
        #1;
        n_vec++;
        if ({idex_valid, idex_opcode, idex_rd, branch_taken} !== {1'b1, 6'h04, 5'd0, 1'b0}) begin
            n_miss++;
            $display("FAIL beq_idex got=%b/%h/%0d/%b exp=1/04/0/0",
                     idex_valid, idex_opcode, idex_rd, branch_taken);
        end
        cyc();
        n_vec++;
        if (idex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL beq_flush got=%b exp=0", idex_valid);
        end
    endtask

    task automatic test_branch_hazard();
        wb_write(5'd4, 32'd5);
        fetch(32'h400, enc_i(6'h05, 5'd4, 5'd0, 16'h0002));
        cyc();
        ex_reg_write = 1'b1; ex_rd = 5'd4;
        fetch(32'h404, NOP);
        #1;
        n_vec++;
        if ({stall, branch_taken} !== 2'b10) begin
            n_miss++;
            $display("FAIL bne_ex_hazard got=%b%b exp=10", stall, branch_taken);
        end
        cyc();
        n_vec++;
        if (idex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL bne_bubble got=%b exp=0", idex_valid);
        end
        ex_reg_write = 1'b0; ex_rd = 5'd0;
        mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result = 32'd0;
        #1;
        n_vec++;
        if ({stall, branch_taken} !== 2'b10) begin
            n_miss++;
            $display("FAIL bne_mem_load_hazard got=%b%b exp=10", stall, branch_taken);
        end
        cyc();
        mem_mem_read = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0;
        #1;
        n_vec++;
        if ({stall, branch_taken, branch_offset} !== {2'b01, 32'd2}) begin
            n_miss++;
            $display("FAIL bne_resolve got=%b%b/%h exp=01/00000002",
                     stall, branch_taken, branch_offset);
        end
        cyc();
        n_vec++;
        if ({idex_valid, idex_opcode, idex_rd, idex_pc} !== {1'b1, 6'h05, 5'd0, 32'h400}) begin
            n_miss++;
            $display("FAIL bne_idex got=%b/%h/%0d/%h exp=1/05/0/00000400",
                     idex_valid, idex_opcode, idex_rd, idex_pc);
        end
    endtask

    task automatic test_jumps();
        logic [31:0] ins;
        ins = enc_j(6'h03, 26'h0100000);
        fetch(32'h0040_0010, ins);
        cyc();
        fetch(32'h0040_0014, NOP);
        sb_q.push_back(exp_idex(32'h0040_0010, ins));
        #1;
        n_vec++;
        if ({jump_taken, branch_taken, new_addr} !== {2'b10, 32'h0010_0000}) begin
            n_miss++;
            $display("FAIL jal_target got=%b%b/%h exp=10/00100000", jump_taken, branch_taken,
                     new_addr);
        end
        cyc();
        got = dut_idex(); exp_b = sb_q.pop_front();
        n_vec++;
        if (got !== exp_b) begin
            n_miss++;
            $display("FAIL jal_idex got=%h exp=%h", got, exp_b);
        end
        ins = enc_j(6'h02, 26'h3FF_FFFF);
        fetch(32'hF000_0000, ins);
        cyc();
        fetch(32'hF000_0004, NOP);
        sb_q.push_back(exp_idex(32'hF000_0000, ins));
        #1;
        n_vec++;
        if ({jump_taken, new_addr} !== {1'b1, 32'h3FFF_FFFF}) begin
            n_miss++;
            $display("FAIL j_target got=%b/%h exp=1/3fffffff", jump_taken, new_addr);
        end
        cyc();
        got = dut_idex(); exp_b = sb_q.pop_front();
        n_vec++;
        if (got !== exp_b) begin
            n_miss++;
            $display("FAIL j_idex got=%h exp=%h", got, exp_b);
        end
        wb_write(5'd31, 32'h0040_0014);
        ins = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
        fetch(32'h0010_0000, ins);
        cyc();
        fetch(32'h0010_0004, NOP);
        sb_q.push_back(exp_idex(32'h0010_0000, ins));
        #1;
        n_vec++;
        if ({jump_taken, new_addr} !== {1'b1, 32'h0010_0005}) begin
            n_miss++;
            $display("FAIL jr_target got=%b/%h exp=1/00100005", jump_taken, new_addr);
        end
        cyc();
        got = dut_idex(); exp_b = sb_q.pop_front();
        n_vec++;
        if (got !== exp_b) begin
            n_miss++;
            $display("FAIL jr_idex got=%h exp=%h", got, exp_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [5];
        prog[0] = enc_i(6'h08, 5'd5, 5'd6, 16'h0010);
        prog[1] = enc_i(6'h23, 5'd8, 5'd7, 16'h0004);
        prog[2] = enc_i(6'h2B, 5'd4, 5'd2, 16'hFFF8);
        prog[3] = enc_r(5'd8, 5'd2, 5'd10, 6'h22);
        prog[4] = enc_i(6'h0D, 5'd4, 5'd11, 16'h8000);
        for (int i = 0; i < 7; i++) begin
            if (i >= 2) begin
                got = dut_idex(); exp_b = sb_q.pop_front();
                n_vec++;
                if (got !== exp_b) begin
                    n_miss++;
                    $display("FAIL b2b_%0d idex got=%h exp=%h", i - 2, got, exp_b);
                end
            end
            if (i < 5) begin
                fetch(32'h500 + 32'(4 * i), prog[i]);
                sb_q.push_back(exp_idex(32'h500 + 32'(4 * i), prog[i]));
            end else begin
                fetch(32'h600, NOP);
            end
            cyc();
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] ins;
        fetch(32'h600, enc_r(5'd8, 5'd2, 5'd1, 6'h20));
        cyc();
        fetch(32'h604, NOP);
        ex_mem_read = 1'b1; ex_rd = 5'd8;
        #1;
        n_vec++;
        if ({stall, idex_valid} !== 2'b11) begin
            n_miss++;
            $display("FAIL pre_reset got=%b%b exp=11", stall, idex_valid);
        end
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({stall, idex_valid, idex_pc, idex_rs_val} !== '0) begin
            n_miss++;
            $display("FAIL async_reset got=%b%b/%h/%h exp=00/0/0", stall, idex_valid, idex_pc,
                     idex_rs_val);
        end
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        cyc();
        rst = 1'b1;
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        ins = enc_r(5'd5, 5'd8, 5'd3, 6'h20);
        fetch(32'h700, ins);
        cyc();
        fetch(32'h704, NOP);
        sb_q.push_back(exp_idex(32'h700, ins));
        cyc();
        got = dut_idex(); exp_b = sb_q.pop_front();
        n_vec++;
        if (got !== exp_b) begin
            n_miss++;
            $display("FAIL regs_cleared idex got=%h exp=%h", got, exp_b);
        end
    endtask

    initial begin
        rst = 1'b0;
        if_pc = '0; if_instruction = NOP;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
        mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0; mem_result = '0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        test_reset();
        test_bypass();
        test_load_use();
        test_beq_forward();
        test_branch_hazard();
        test_jumps();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
